mips_pipe_stage: RTL and testbench
==================================

# mips_pipe_stage

Parametrised inter-stage pipeline register for the MIPS pipeline, usable at any stage boundary: IF/ID, ID/EX, EX/MEM or MEM/WB. It carries a control-bit bus and a data payload under a valid/ready handshake, with synchronous flush that inserts a bubble. An optional skid buffer removes the combinational ready path, and a saturating counter records back-pressure cycles for performance analysis.

## Interface
- DATA_W, 69: payload width (MEM/WB default: ReadData 32 + ALUResult 32 + WriteRegister 5)
- CTRL_W, 2: control-bit width (MEM/WB default: MemtoReg, RegWrite)
- CNT_W, 16: stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- flush  in  1  synchronous bubble request
- in_valid  in  1  upstream has a word
- in_ready  out  1  stage can accept
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  stage holds a valid word
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  registered control bits, forced 0 when not valid
- out_data  out  DATA_W  registered payload
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Priority: reset > flush > normal operation.
- Reset value of every output:
  - out_valid = 0, out_ctrl = 0, out_data = 0, stall_cnt = 0.
  - in_ready = 0 while reset is high.
  - in_ready = 1 in the first cycle after reset deasserts.
- Flush:
  - Next cycle: out_valid = 0, out_ctrl = 0, and any skid entry is discarded.
  - out_data keeps its value.
  - in_ready = 0 during the flush cycle, so no word is accepted.
  - stall_cnt is unaffected.
- Bubble rule: whenever out_valid = 0, out_ctrl = 0. A stale write-enable can never reach the next stage.
- Main register, without the skid buffer:
  - in_ready = !flush && (!out_valid || out_ready).
  - Transfer in: main register <= input, out_valid <= 1.
  - Transfer out with no transfer in: out_valid <= 0, out_ctrl <= 0.
  - Simultaneous transfer in and out: the main register is replaced and out_valid stays 1, giving full throughput.
- Stall counter:
  - Increments each cycle that out_valid && !out_ready.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - Cleared only by reset.

## Timing
- Latency: a word accepted at edge N appears on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 word per cycle when out_ready is held at 1.
- Hold: when out_valid && !out_ready, out_ctrl and out_data are stable until the transfer out.
- No combinational path from in_* to out_*.
- Without the skid buffer there is a combinational path from out_ready and flush to in_ready.
- Flush and a transfer out in the same cycle: the downstream word is consumed and the stage goes empty.
- Reset asserted mid-transfer: the word is lost. No partial state survives.

## Configuration
- Macro: PIPE_STAGE_SKID_EN.
- Defined:
  - Adds one skid entry (ctrl, data, skid_valid).
  - in_ready = !flush && !skid_valid, a registered term, so out_ready does not reach in_ready.
  - A word accepted while the main register is occupied and out_ready = 0 goes to the skid entry.
  - On the next transfer out, the skid entry moves to the main register. out_valid stays 1 and skid_valid clears.
  - Ordering is preserved; latency and throughput are unchanged.
- Undefined:
  - Single register only.
  - in_ready follows the combinational formula in Operation.
- Both builds have identical reset, flush and counter behaviour.

## Structure
- Shared package mips_pipe_pkg holds:
  - the default widths, and
  - per-boundary constants: MEMWB_DATA_W = 69, MEMWB_CTRL_W = 2, EXMEM_DATA_W, IDEX_DATA_W.
- Instances at each boundary pack and unpack their fields from those constants.
- One sub-module, mips_sat_counter (parameter CNT_W; inputs inc, clr), implements stall_cnt and is reusable by other performance counters.

## Test plan
1. Reset held 3 cycles with in_valid = 1, in_data = 0xDEAD -> all outputs 0 and in_ready = 0 throughout; after release, in_ready = 1 and out_valid = 0.
2. Stream 4 words (data 1..4, ctrl 2'b11) with out_ready = 1 -> each appears 1 cycle after acceptance, back to back, out_valid high for 4 consecutive cycles.
3. Accept word 0x5 (ctrl 2'b10), then out_ready = 0 for 5 cycles -> out_data = 0x5 stable and stall_cnt = 5. With CNT_W = 2, stall_cnt saturates at 3.
4. out_valid = 1 with ctrl 2'b01, assert flush with in_valid = 1 -> next cycle out_valid = 0 and out_ctrl = 0; in_ready = 0 during the flush cycle and the input word is never output.
5. With PIPE_STAGE_SKID_EN: accept A, drop out_ready, accept B -> in_ready falls to 0; raise out_ready -> A then B output in order on consecutive cycles, and in_ready returns to 1.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
// Shared constants for the MIPS inter-stage pipeline registers.
// Holds the default widths of mips_pipe_stage and the per-boundary payload
// and control widths, plus packed field layouts that instances at each
// boundary use to pack and unpack their fields.
package mips_pipe_pkg;

    // Default widths of mips_pipe_stage (MEM/WB boundary).
    localparam int DEF_DATA_W = 69;
    localparam int DEF_CTRL_W = 2;
    localparam int DEF_CNT_W  = 16;

    // MEM/WB: ReadData 32 + ALUResult 32 + WriteRegister 5; MemtoReg, RegWrite.
    localparam int MEMWB_DATA_W = 69;
    localparam int MEMWB_CTRL_W = 2;

    // EX/MEM: BranchTarget 32 + Zero 1 + ALUResult 32 + WriteData 32 + WriteRegister 5;
    // Branch, MemRead, MemWrite, MemtoReg, RegWrite.
    localparam int EXMEM_DATA_W = 102;
    localparam int EXMEM_CTRL_W = 5;

    // ID/EX: PC+4 32 + ReadData1 32 + ReadData2 32 + SignImm 32 + Rt 5 + Rd 5;
    // RegDst, ALUSrc, ALUOp[1:0], Branch, MemRead, MemWrite, MemtoReg, RegWrite.
    localparam int IDEX_DATA_W = 138;
    localparam int IDEX_CTRL_W = 9;

    // IF/ID: Instruction 32 + PC+4 32; no control bits of its own.
    localparam int IFID_DATA_W = 64;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  write_reg;
    } memwb_data_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } memwb_ctrl_t;

endpackage

// File: rtl/mips_sat_counter.sv
// mips_sat_counter
// Saturating up-counter for performance statistics. Counts cycles in which
// inc is high, holds at all-ones instead of wrapping, and clears
// synchronously on clr (clr has priority over inc).
// Ports:
//   clk   in   clock
//   clr   in   synchronous clear
//   inc   in   count enable for this cycle
//   count out  current count (CNT_W bits)
module mips_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_pipe_stage.sv
// mips_pipe_stage
// Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries a control bus and a data payload under valid/ready, with a
// synchronous flush that inserts a bubble, and a saturating count of
// back-pressured cycles.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   : one skid entry; in_ready depends only on registered state,
//               flush and reset (no out_ready -> in_ready path).
//   undefined : single register; in_ready = !flush && (!out_valid || out_ready).
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   flush      in   synchronous bubble request
//   in_valid   in   upstream has a word
//   in_ready   out  stage can accept (0 while reset or flush is high)
//   in_ctrl    in   upstream control bits  [CTRL_W]
//   in_data    in   upstream payload       [DATA_W]
//   out_valid  out  stage holds a valid word
//   out_ready  in   downstream accepts
//   out_ctrl   out  registered control bits, 0 whenever out_valid is 0
//   out_data   out  registered payload (kept across flush)
//   stall_cnt  out  saturating count of cycles with out_valid && !out_ready
//
// Handshake: a word moves across a port on a rising edge where that port's
// valid and ready are both high; valid never waits on ready, and a valid
// word with ready low holds ctrl/data unchanged until it is taken.
module mips_pipe_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    logic xfer_in;
    logic xfer_out;

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;

    // While the skid entry is occupied no further word is taken, so a
    // transfer in never coincides with the skid draining into main.
    assign in_ready = !reset && !flush && !skid_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            data_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else if (flush) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
        end else if (xfer_out) begin
            if (skid_valid_q) begin
                ctrl_q       <= skid_ctrl_q;
                data_q       <= skid_data_q;
                skid_valid_q <= 1'b0;
                skid_ctrl_q  <= '0;
            end else if (xfer_in) begin
                ctrl_q <= in_ctrl;
                data_q <= in_data;
            end else begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end
        end else if (xfer_in) begin
            // Main is busy and not draining: park the word in the skid entry.
            if (valid_q) begin
                skid_valid_q <= 1'b1;
                skid_ctrl_q  <= in_ctrl;
                skid_data_q  <= in_data;
            end else begin
                valid_q <= 1'b1;
                ctrl_q  <= in_ctrl;
                data_q  <= in_data;
            end
        end
    end
`else
    assign in_ready = !reset && !flush && (!valid_q || out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (xfer_in) begin
            valid_q <= 1'b1;
            ctrl_q  <= in_ctrl;
            data_q  <= in_data;
        end else if (xfer_out) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end
    end
`endif

    assign out_valid = valid_q;
    // Gate again at the output so a stale write-enable can never escape.
    assign out_ctrl  = valid_q ? ctrl_q : '0;
    assign out_data  = data_q;

    mips_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (reset),
        .inc  (valid_q && !out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_mips_pipe_stage.sv
// tb_mips_pipe_stage
// Self-checking bench for mips_pipe_stage. A second instance with CNT_W = 2
// shares all inputs to observe counter saturation. The reference model keeps
// the words held by the stage as a queue whose capacity is 1 (or 2 with
// PIPE_STAGE_SKID_EN).
module tb_mips_pipe_stage;

    localparam int DW  = 69;
    localparam int CW  = 2;
    localparam int NW  = 16;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    logic          s2_in_ready;
    logic          s2_out_valid;
    logic [CW-1:0] s2_out_ctrl;
    logic [DW-1:0] s2_out_data;
    logic [1:0]    s2_stall_cnt;

    always #5 clk = ~clk;

    mips_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    mips_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s2_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s2_out_valid), .out_ready(out_ready), .out_ctrl(s2_out_ctrl), .out_data(s2_out_data),
        .stall_cnt(s2_stall_cnt)
    );

    // ---------------- scoreboard / model ----------------
    logic [CW+DW-1:0] exp_q[$];   // {ctrl, data}, front = word on out_*
    logic [DW-1:0]    m_data;     // payload of the main register
    int               m_cnt;
    int               m_cnt2;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle: apply inputs after the falling edge, compare the DUT
    // against the model just before the rising edge, then advance the model.
    task automatic step(input bit r, input bit f, input bit iv,
                        input logic [CW-1:0] ic, input logic [DW-1:0] id, input bit ordy);
        bit exp_ready;
        bit pop;
        bit push;
        @(negedge clk);
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        #1;
        if (CAP == 2) exp_ready = !r && !f && (exp_q.size() < 2);
        else          exp_ready = !r && !f && (exp_q.size() == 0 || ordy);
        check_eq("in_ready", in_ready, exp_ready);
        check_eq("out_valid", out_valid, exp_q.size() > 0);
        check_eq("out_ctrl", out_ctrl, (exp_q.size() > 0) ? exp_q[0][DW +: CW] : '0);
        check_eq("out_data", out_data, m_data);
        check_eq("stall_cnt", stall_cnt, m_cnt);
        check_eq("stall_cnt_w2", s2_stall_cnt, m_cnt2);
        pop  = (exp_q.size() > 0) && ordy;
        push = iv && exp_ready;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_data = '0;
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            if (exp_q.size() > 0 && !ordy) begin
                if (m_cnt  < (1 << NW) - 1) m_cnt++;
                if (m_cnt2 < 3)             m_cnt2++;
            end
            if (f) begin
                exp_q.delete();
            end else begin
                if (pop)  void'(exp_q.pop_front());
                if (push) exp_q.push_back({ic, id});
                if (exp_q.size() > 0) m_data = exp_q[0][DW-1:0];
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [95:0] rnd;
        // Preamble edge so the state is defined before checking begins.
        @(posedge clk);
        exp_q.delete();
        m_data = '0;
        m_cnt  = 0;
        m_cnt2 = 0;

        // 1: reset held with a word presented.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 2'b11, 69'hDEAD, 1);
        step(0, 0, 0, '0, '0, 1);

        // 2: four words back to back.
        for (int i = 1; i <= 4; i++) step(0, 0, 1, 2'b11, DW'(i), 1);
        step(0, 0, 0, '0, '0, 1);
        step(0, 0, 0, '0, '0, 1);

        // 3: hold under back-pressure, counter counts 5 (saturates at 3 for CNT_W=2).
        step(1, 0, 0, '0, '0, 1);
        step(0, 0, 1, 2'b10, 69'h5, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0, '0, 0);
        step(0, 0, 0, '0, '0, 1);
        step(0, 0, 0, '0, '0, 1);

        // 4: flush with a word presented.
        step(0, 0, 1, 2'b01, 69'h77, 1);
        step(0, 1, 1, 2'b11, 69'h99, 0);
        step(0, 0, 0, '0, '0, 1);
        step(0, 0, 0, '0, '0, 1);

        // 5: A, then B under back-pressure (goes to skid when enabled), drain.
        step(0, 0, 1, 2'b01, 69'hA, 1);
        step(0, 0, 1, 2'b10, 69'hB, 0);
        step(0, 0, 1, 2'b11, 69'hC, 0);
        step(0, 0, 0, '0, '0, 1);
        step(0, 0, 0, '0, '0, 1);
        step(0, 0, 0, '0, '0, 1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0,
                 CW'($urandom_range(0, 3)),
                 rnd[DW-1:0],
                 $urandom_range(0, 2) != 0);
        end
        step(0, 0, 0, '0, '0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog: the run is bounded by its loops; this only guards a stuck clock.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
